// File: rtl/pim_req_sequencer_pkg.sv
// Shared definitions for the PIM request sequencer: command encodings,
// sequencer states and the bank configuration value used out of reset.
package pim_req_sequencer_pkg;

    localparam int CFG_W = 28;

    // Bank configuration presented while no command has been accepted.
    localparam logic [CFG_W-1:0] CFG_DEFAULT = 28'h851F;

    typedef enum logic [1:0] {
        OP_VECA_LOAD = 2'd0,
        OP_ELEM      = 2'd1,
        OP_CLEAR     = 2'd2,
        OP_RSVD      = 2'd3
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_VECA  = 3'd1,
        ST_A_RD  = 3'd2,
        ST_B_RD  = 3'd3,
        ST_C_WR  = 3'd4,
        ST_CLR   = 3'd5,
        ST_DRAIN = 3'd6,
        ST_DONE  = 3'd7
    } state_t;

    // Ops whose work is counted in beats; a zero length skips straight to DONE.
    function automatic logic op_uses_len(input op_t op);
        return (op == OP_VECA_LOAD) || (op == OP_ELEM);
    endfunction

endpackage

// File: rtl/pim_req_sequencer_res_tracker.sv
// Result-latency tracker: one bit per dst_C_WR_pass travels down a RES_LAT
// deep shift register; the bit leaving the last stage marks the cycle in
// which the bank result is valid.
module pim_res_tracker #(
    parameter int RES_LAT = 3    // legal range 1..7
) (
    input  logic clk,
    input  logic rst_x,
    input  logic i_push,         // a C write was issued this cycle
    output logic o_hit,          // result for an earlier C write is valid now
    output logic o_nonempty      // some result is still due in a later cycle
);

    logic [RES_LAT-1:0] r_shift;

    if (RES_LAT == 1) begin : g_single
        // Single-stage delay line.
        always_ff @(posedge clk or negedge rst_x) begin
            if (!rst_x) begin
                r_shift <= '0;
            end else begin
                r_shift <= i_push;
            end
        end
    end else begin : g_multi
        // Shift the issue marker one stage per cycle toward the output.
        always_ff @(posedge clk or negedge rst_x) begin
            if (!rst_x) begin
                r_shift <= '0;
            end else begin
                r_shift <= {r_shift[RES_LAT-2:0], i_push};
            end
        end
    end

    assign o_hit = r_shift[RES_LAT-1];

    // The output stage is excluded: a marker there is being retired this
    // cycle, so the drain can finish in the same cycle it is delivered.
    always_comb begin
        o_nonempty = 1'b0;
        for (int i = 0; i < RES_LAT - 1; i++) begin
            o_nonempty = o_nonempty | r_shift[i];
        end
    end

endmodule

// File: rtl/pim_req_sequencer.sv
// PIM request sequencer: accepts one command at a time and turns it into
// bank-side strobes (vector-A writes, elementwise A/B/C beats or a clear),
// then collects the delayed bank results before signalling completion.
//
// Handshakes: cmd_valid/cmd_ready and in_valid/in_ready transfer exactly on
// a rising edge where both are high; the sequencer never withdraws ready
// within a state and the producer may hold valid as long as it likes. The
// result stream res_valid/res_data has no backpressure.
module pim_req_sequencer
    import pim_req_sequencer_pkg::*;
#(
    parameter int DATA_W  = 256,
    parameter int LEN_W   = 8,
    parameter int RES_LAT = 3
) (
    input  logic              clk,
    input  logic              rst_x,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [CFG_W-1:0]  cmd_cfg,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] req_data,
    output logic              req_MM_vecA_write,
    output logic              src_A_RD_pass,
    output logic              src_B_RD_pass,
    output logic              dst_C_WR_pass,
    output logic              HPC_clear_sig,
    output logic [CFG_W-1:0]  bank_config,
    input  logic [DATA_W-1:0] PIM_result,
    output logic              res_valid,
    output logic [DATA_W-1:0] res_data,
    output logic              done,
    output logic              err,
    output state_t            dbg_state
);

    state_t             r_state;
    state_t             w_next_state;
    op_t                r_op;
    logic [LEN_W-1:0]   r_beats;
    logic [CFG_W-1:0]   r_cfg;
    logic [DATA_W-1:0]  r_req_data;
    logic               r_vecA_write;

    logic               w_cmd_fire;
    logic               w_beat_fire;
    logic               w_res_hit;
    logic               w_res_pending;
    op_t                w_cmd_op;

    assign w_cmd_op    = op_t'(cmd_op);
    assign w_cmd_fire  = cmd_valid & cmd_ready;
    assign w_beat_fire = in_valid & in_ready;

    // State register; reset parks the sequencer in IDLE and drops any command.
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and strobe decode; strobes come straight from the state so
    // at most one of them can be high in any cycle.
    always_comb begin
        w_next_state  = r_state;
        cmd_ready     = 1'b0;
        in_ready      = 1'b0;
        src_A_RD_pass = 1'b0;
        src_B_RD_pass = 1'b0;
        dst_C_WR_pass = 1'b0;
        HPC_clear_sig = 1'b0;
        done          = 1'b0;
        err           = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Held low while rst_x is asserted so every output reads 0.
                cmd_ready = rst_x;
                if (cmd_valid) begin
                    if (op_uses_len(w_cmd_op) && (cmd_len == '0)) begin
                        w_next_state = ST_DONE;
                    end else begin
                        case (w_cmd_op)
                            OP_VECA_LOAD: w_next_state = ST_VECA;
                            OP_ELEM:      w_next_state = ST_A_RD;
                            OP_CLEAR:     w_next_state = ST_CLR;
                            default:      w_next_state = ST_DONE;
                        endcase
                    end
                end
            end
            ST_VECA: begin
                in_ready = 1'b1;
                if (in_valid && (r_beats == LEN_W'(1))) begin
                    w_next_state = ST_DRAIN;
                end
            end
            ST_A_RD: begin
                src_A_RD_pass = 1'b1;
                w_next_state  = ST_B_RD;
            end
            ST_B_RD: begin
                src_B_RD_pass = 1'b1;
                w_next_state  = ST_C_WR;
            end
            ST_C_WR: begin
                dst_C_WR_pass = 1'b1;
                w_next_state  = (r_beats == LEN_W'(1)) ? ST_DRAIN : ST_A_RD;
            end
            ST_CLR: begin
                HPC_clear_sig = 1'b1;
                w_next_state  = ST_DONE;
            end
            ST_DRAIN: begin
                if (!w_res_pending) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                done         = 1'b1;
                err          = (r_op == OP_RSVD);
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Command latch and beat counter; VECA counts accepted beats, ELEM counts
    // completed A/B/C triples.
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            r_op    <= OP_VECA_LOAD;
            r_beats <= '0;
            r_cfg   <= CFG_DEFAULT;
        end else if (w_cmd_fire) begin
            r_op    <= w_cmd_op;
            r_beats <= cmd_len;
            r_cfg   <= cmd_cfg;
        end else if (w_beat_fire || (r_state == ST_C_WR)) begin
            r_beats <= r_beats - LEN_W'(1);
        end
    end

    // Vector-A write path: an accepted beat appears on req_data with a write
    // pulse one cycle later; req_data keeps its value between beats.
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            r_req_data   <= '0;
            r_vecA_write <= 1'b0;
        end else begin
            r_vecA_write <= w_beat_fire;
            if (w_beat_fire) begin
                r_req_data <= in_data;
            end
        end
    end

    pim_res_tracker #(
        .RES_LAT    (RES_LAT)
    ) u_res_tracker (
        .clk        (clk),
        .rst_x      (rst_x),
        .i_push     (dst_C_WR_pass),
        .o_hit      (w_res_hit),
        .o_nonempty (w_res_pending)
    );

    assign req_data          = r_req_data;
    assign req_MM_vecA_write = r_vecA_write;
    assign bank_config       = r_cfg;
    assign res_valid         = w_res_hit;
    assign res_data          = w_res_hit ? PIM_result : '0;
    assign dbg_state         = r_state;

endmodule
